// File: rtl/mem_access_unit.sv
// Memory access unit: sequences single-word or burst loads/stores as one
// request/valid/finish handshake per beat, with per-phase timeout and error report.
module mem_access_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 255,
  localparam int LEN_W    = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LEN_W-1:0]  cpu_len,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              wdata_take,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] addr,
  output logic              read_mem_req,
  output logic              write_mem_req,
  input  logic              read_mem_valid,
  input  logic              write_mem_valid,
  input  logic              read_mem_finish,
  input  logic              write_mem_finish,
  input  logic [DATA_W-1:0] in_mem_data,
  output logic [DATA_W-1:0] out_mem_data
);

  // The counter only has to reach TIMEOUT-1: the phase ends on that cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(BURST_MAX);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [LEN_W-1:0]  beats_reg;
  logic [LEN_W-1:0]  len_eff;
  logic              is_rd;
  logic              in_req;
  logic              in_wait;
  logic              ch_valid;
  logic              ch_finish;
  logic              beat_fire;
  logic              to_wait;
  logic              tmo_hit;

  always_comb begin
    len_eff = cpu_len;
    if (cpu_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (cpu_len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
  end

  // Only the channel of the active command is listened to.
  always_comb begin
    is_rd     = (state_reg == RD_REQ) || (state_reg == RD_WAIT);
    in_req    = (state_reg == RD_REQ) || (state_reg == WR_REQ);
    in_wait   = (state_reg == RD_WAIT) || (state_reg == WR_WAIT);
    ch_valid  = is_rd ? read_mem_valid  : write_mem_valid;
    ch_finish = is_rd ? read_mem_finish : write_mem_finish;
    beat_fire = (in_req && ch_valid && ch_finish) || (in_wait && ch_finish);
    to_wait   = in_req && ch_valid && !ch_finish;
    tmo_hit   = (TIMEOUT > 0) && (cnt_reg == TMO_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      beats_reg     <= '0;
      wdata_take    <= 1'b0;
      rdata         <= '0;
      rdata_valid   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      addr          <= '0;
      read_mem_req  <= 1'b0;
      write_mem_req <= 1'b0;
      out_mem_data  <= '0;
    end else begin
      wdata_take  <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (state_reg == IDLE) begin
        if (start) begin
          addr      <= cpu_addr;
          beats_reg <= len_eff;
          cnt_reg   <= '0;
          busy      <= 1'b1;
          if (op) begin
            state_reg     <= WR_REQ;
            write_mem_req <= 1'b1;
            wdata_take    <= 1'b1;
            out_mem_data  <= cpu_wdata;
          end else begin
            state_reg    <= RD_REQ;
            read_mem_req <= 1'b1;
          end
        end
      end else if (beat_fire) begin
        cnt_reg <= '0;
        if (is_rd) begin
          rdata       <= in_mem_data;
          rdata_valid <= 1'b1;
        end
        if (beats_reg == LEN_W'(1)) begin
          state_reg     <= IDLE;
          busy          <= 1'b0;
          done          <= 1'b1;
          read_mem_req  <= 1'b0;
          write_mem_req <= 1'b0;
          beats_reg     <= '0;
        end else begin
          beats_reg <= beats_reg - LEN_W'(1);
          addr      <= addr + ADDR_W'(1);
          if (is_rd) begin
            state_reg    <= RD_REQ;
            read_mem_req <= 1'b1;
          end else begin
            state_reg     <= WR_REQ;
            write_mem_req <= 1'b1;
            wdata_take    <= 1'b1;
            out_mem_data  <= cpu_wdata;
          end
        end
      end else if (to_wait) begin
        state_reg     <= is_rd ? RD_WAIT : WR_WAIT;
        read_mem_req  <= 1'b0;
        write_mem_req <= 1'b0;
        cnt_reg       <= '0;
      end else if (tmo_hit) begin
        // Abort: remaining beats are dropped and the error is reported with done.
        state_reg     <= IDLE;
        busy          <= 1'b0;
        done          <= 1'b1;
        err           <= 1'b1;
        read_mem_req  <= 1'b0;
        write_mem_req <= 1'b0;
        cnt_reg       <= '0;
        beats_reg     <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule
